// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer. Every accumulate is routed through the
// shared external ALU in ADD mode; the sequencer only shifts and steers.
module alu_mul_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] OP_ADD = 3'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                // Early exit as soon as no multiplier bits remain to be consumed.
                if (mplier_q == '0) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = alu_f;
                    end
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign alu_op = OP_ADD;
    assign alu_a  = acc_q;
    assign alu_b  = mcand_q;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-and-add multiplier sequencer that drives the shared 32-bit combinational ALU through its ALU_OP/A/B/F pins.
- It never computes sums itself: every accumulate goes through the external ALU in ADD mode.
- Produces the unsigned low-WIDTH-bit product of two operands, with a start/busy/done handshake.
- Terminates early once the remaining multiplier bits are zero.

Parameters:
- WIDTH, 32, operand/result/ALU data width.
- OP_ADD, 3'd4, ALU opcode driven on alu_op (ALU ADD encoding).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- op_a  input  WIDTH  multiplicand, latched on an accepted start.
- op_b  input  WIDTH  multiplier, latched on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  low WIDTH bits of op_a*op_b; held until the next accepted start.
- alu_op  output  3  ALU opcode, constant OP_ADD.
- alu_a  output  WIDTH  ALU A input = accumulator register.
- alu_b  output  WIDTH  ALU B input = shifted multiplicand register.
- alu_f  input  WIDTH  ALU F result (combinational from alu_a/alu_b).

Behaviour:
- Registers: state, acc, mcand, mplier, result.
- Reset (async, rst=1):
  - state=IDLE, acc=0, mcand=0, mplier=0, result=0.
  - Therefore busy=0, done=0, alu_a=0, alu_b=0.
  - Takes effect immediately, including mid-RUN; the operation in flight is discarded and no done is issued.
- States and transitions:
  - IDLE: busy=0, done=0.
    - start=1: acc<=0, mcand<=op_a, mplier<=op_b, go RUN.
    - Otherwise stay in IDLE.
  - RUN: busy=1, done=0. Each cycle:
    - If mplier==0: result<=acc, go DONE.
    - Else: if mplier[0]=1 then acc<=alu_f (acc+mcand mod 2^WIDTH), else acc unchanged. Also mcand<=mcand<<1 (zero fill, MSB discarded), mplier<=mplier>>1 (zero fill). Stay in RUN.
    - start is ignored in RUN.
  - DONE: busy=0, done=1 for exactly this one cycle.
    - start=1: accept exactly as from IDLE, go RUN (back-to-back operation).
    - Otherwise go IDLE.
- Outputs: alu_op is a constant OP_ADD in all states including reset. busy and done are decoded from state.
- Latency: the start-accept cycle is cycle 0.
  - RUN occupies cycles 1..msb(op_b)+2; done is high in cycle msb(op_b)+3.
  - msb = index of the highest set bit.
  - op_b==0: one RUN cycle, done in cycle 2.
  - Maximum: op_b[WIDTH-1]=1 gives done in cycle WIDTH+2.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - High product bits and ALU OF/ZF are not used and not reported.
  - Signed operands yield the correct two's-complement low word.
- result:
  - Updates only on the RUN->DONE transition.
  - Stable from that point through IDLE until the next completion.
  - Not cleared by a new start.
- The ALU may be shared by other logic only while busy=0; the sequencer does not arbitrate it.

Test Plan:
- Reset then op_a=3, op_b=5, start pulse (cycle 0) -> busy cycles 1-4, done=1 only in cycle 5, result=15, then IDLE with result held at 15.
- op_a=0x1234, op_b=0 -> one RUN cycle, done in cycle 2, result=0.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done in cycle 34, result=0x00000001. alu_op reads 3'd4 every cycle.
- op_a=7, op_b=6, with start held high in cycles 1-3 -> start ignored in RUN. Done in cycle 5, result=42. Start high in the DONE cycle with op_a=2, op_b=3 -> immediate RUN, second done 4 cycles later, result=6.
- op_a=0x80000000, op_b=2 -> result=0 (shifted-out bit discarded), done in cycle 4.
- Start op_a=9, op_b=0xFFFF; assert rst asynchronously in cycle 5 -> busy=0 and state=IDLE without waiting for a clock edge, result=0, no done pulse. After release, 4*4 -> result=16.
